// File: rtl/tape_pkg.sv
// Shared encodings for the tape buffer arbiter: transport mode, memory FSM state and grant source.
package tape_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    RECORD = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    M_IDLE   = 2'd0,
    M_RD     = 2'd1,
    M_WR     = 2'd2,
    M_LDWAIT = 2'd3
  } mstate_e;

  typedef enum logic [1:0] {
    GNT_NONE   = 2'd0,
    GNT_HOST   = 2'd1,
    GNT_SAVER  = 2'd2,
    GNT_LOADER = 2'd3
  } gnt_e;

endpackage

// File: rtl/tape_mem_arbiter_if.sv
// Byte-wide SDRAM request port: strobes held until a one-cycle ack; read data valid with ack.
interface tape_mem_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/tape_req_prio.sv
// Combinational fixed-priority grant: host over saver over loader.
module tape_req_prio
  import tape_pkg::*;
(
  input  logic host_el,
  input  logic sv_el,
  input  logic ld_el,
  output gnt_e gnt
);

  always_comb begin
    gnt = GNT_NONE;
    if (host_el)    gnt = GNT_HOST;
    else if (sv_el) gnt = GNT_SAVER;
    else if (ld_el) gnt = GNT_LOADER;
  end

endmodule

// File: rtl/tape_mem_arbiter.sv
// Tape byte buffer controller: play/record mode, pointers and length, one SDRAM transaction at a time.
// Grants only from M_IDLE; loader results appear the cycle after mem_ack and hold until ld_req drops.
module tape_mem_arbiter
  import tape_pkg::*;
#(
  parameter int                ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(24'h100000)
) (
  input  logic              clk50m,
  input  logic              reset,
  input  logic              cmd_play,
  input  logic              cmd_record,
  input  logic              cmd_stop,
  input  logic              cmd_rewind,
  input  logic              host_wr,
  input  logic [7:0]        host_data,
  input  logic              host_clear,
  output logic              host_busy,
  input  logic              ld_req,
  output logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              ld_dend,
  input  logic              sv_valid,
  input  logic              sv_end,
  input  logic [7:0]        sv_data,
  output logic              sv_ack,
  output logic              play,
  output logic              recording,
  output logic              overflow,
  output logic [ADDR_W-1:0] tape_len,
  tape_mem_arbiter_if.master mem
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  mode_e             mode, mode_nxt;
  mstate_e           mst, mst_nxt;
  gnt_e              gnt, wr_src;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]        host_byte;
  logic              sv_pend, wclr_pend, rclr_pend;
  logic              host_el, sv_el, ld_el, end_evt, at_limit, do_record;
  logic              wclr_req, rclr_req, wclr_now, rclr_now;

  assign do_record = cmd_record & ~cmd_rewind & ~cmd_stop;
  assign wclr_req  = host_clear | do_record;
  assign rclr_req  = host_clear | cmd_rewind;
  // Clears landing on an in-flight access wait for its ack so the completion cannot undo them.
  assign wclr_now  = (wclr_req | wclr_pend) & ~(mem.mem_wr & ~mem.mem_ack);
  assign rclr_now  = (rclr_req | rclr_pend) & ~(mem.mem_rd & ~mem.mem_ack);

  assign host_el   = host_busy & (mode != PLAY) & ~wclr_req;
  assign sv_el     = (mode == RECORD) & sv_valid & ~sv_pend & ~wclr_req;
  assign ld_el     = (mode == PLAY) & ld_req & ~ld_ready & ~rclr_req;
  assign end_evt   = sv_end & ~sv_valid & ~sv_pend;
  assign at_limit  = (wr_ptr == ADDR_MAX);

  assign play      = (mode == PLAY);
  assign recording = (mode == RECORD);

  tape_req_prio u_prio (
    .host_el (host_el),
    .sv_el   (sv_el),
    .ld_el   (ld_el),
    .gnt     (gnt)
  );

  always_ff @(posedge clk50m) begin
    if (reset) begin
      mode <= IDLE;
      mst  <= M_IDLE;
    end else begin
      mode <= mode_nxt;
      mst  <= mst_nxt;
    end
  end

  always_comb begin
    mode_nxt = mode;
    if (cmd_rewind || cmd_stop)               mode_nxt = IDLE;
    else if (cmd_record)                      mode_nxt = RECORD;
    else if (cmd_play && mode != RECORD)      mode_nxt = PLAY;
    else if (end_evt)                         mode_nxt = IDLE;
  end

  always_comb begin
    mst_nxt = mst;
    case (mst)
      M_IDLE: begin
        if ((gnt == GNT_HOST || gnt == GNT_SAVER) && !at_limit) mst_nxt = M_WR;
        else if (gnt == GNT_LOADER) mst_nxt = (rd_ptr >= tape_len) ? M_LDWAIT : M_RD;
      end
      M_RD:     if (mem.mem_ack) mst_nxt = M_LDWAIT;
      M_WR:     if (mem.mem_ack) mst_nxt = M_IDLE;
      M_LDWAIT: if (!ld_req)     mst_nxt = M_IDLE;
      default:  mst_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk50m) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tape_len      <= '0;
      overflow      <= 1'b0;
      host_busy     <= 1'b0;
      host_byte     <= '0;
      sv_pend       <= 1'b0;
      sv_ack        <= 1'b0;
      ld_ready      <= 1'b0;
      ld_data       <= '0;
      ld_dend       <= 1'b0;
      wr_src        <= GNT_NONE;
      wclr_pend     <= 1'b0;
      rclr_pend     <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_rd    <= 1'b0;
      mem.mem_wr    <= 1'b0;
    end else begin
      if (sv_pend && !sv_valid && !sv_end) sv_pend <= 1'b0;
      if (end_evt) begin
        sv_ack  <= ~sv_ack;
        sv_pend <= 1'b1;
      end
      case (mst)
        M_IDLE: begin
          if (gnt == GNT_HOST || gnt == GNT_SAVER) begin
            wr_src <= gnt;
            if (at_limit) begin
              // Dropped write still completes the requester's handshake.
              overflow <= 1'b1;
              if (gnt == GNT_HOST) host_busy <= 1'b0;
              else begin
                sv_ack  <= ~sv_ack;
                sv_pend <= 1'b1;
              end
            end else begin
              mem.mem_wr    <= 1'b1;
              mem.mem_addr  <= BASE_ADDR + wr_ptr;
              mem.mem_wdata <= (gnt == GNT_HOST) ? host_byte : sv_data;
            end
          end else if (gnt == GNT_LOADER) begin
            if (rd_ptr >= tape_len) begin
              ld_data  <= '0;
              ld_dend  <= 1'b1;
              ld_ready <= 1'b1;
            end else begin
              mem.mem_rd   <= 1'b1;
              mem.mem_addr <= BASE_ADDR + rd_ptr;
            end
          end
        end
        M_RD: if (mem.mem_ack) begin
          mem.mem_rd <= 1'b0;
          ld_data    <= mem.mem_rdata;
          ld_dend    <= 1'b0;
          ld_ready   <= 1'b1;
          rd_ptr     <= rd_ptr + ADDR_W'(1);
        end
        M_WR: if (mem.mem_ack) begin
          mem.mem_wr <= 1'b0;
          wr_ptr     <= wr_ptr + ADDR_W'(1);
          tape_len   <= wr_ptr + ADDR_W'(1);
          if (wr_src == GNT_HOST) host_busy <= 1'b0;
          else begin
            sv_ack  <= ~sv_ack;
            sv_pend <= 1'b1;
          end
        end
        M_LDWAIT: if (!ld_req) ld_ready <= 1'b0;
        default: ;
      endcase
      if (host_wr) begin
        host_byte <= host_data;
        host_busy <= 1'b1;
      end
      if (do_record) overflow <= 1'b0;
      if (wclr_now) begin
        wr_ptr    <= '0;
        tape_len  <= '0;
        wclr_pend <= 1'b0;
      end else if (wclr_req) begin
        wclr_pend <= 1'b1;
      end
      if (rclr_now) begin
        rd_ptr    <= '0;
        rclr_pend <= 1'b0;
      end else if (rclr_req) begin
        rclr_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tape_mem_arbiter.sv
// Directed bench: a 24-bit instance against a latency-2 memory stub, plus a 4-bit-address instance for the limit case.
module tb_tape_mem_arbiter;

  localparam logic [23:0] BASE = 24'h100000;

  logic        clk50m = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_play = 1'b0, cmd_record = 1'b0, cmd_stop = 1'b0, cmd_rewind = 1'b0;
  logic        host_wr = 1'b0, host_clear = 1'b0;
  logic [7:0]  host_data = 8'h00;
  logic        ld_req = 1'b0;
  logic        sv_valid = 1'b0, sv_end = 1'b0;
  logic [7:0]  sv_data = 8'h00;

  logic        host_busy, ld_ready, ld_dend, sv_ack, play, recording, overflow;
  logic [7:0]  ld_data;
  logic [23:0] tape_len;
  logic        host_busy4, ld_ready4, ld_dend4, sv_ack4, play4, recording4, overflow4;
  logic [7:0]  ld_data4;
  logic [3:0]  tape_len4;

  int n_tests = 0;
  int n_fail  = 0;

  tape_mem_arbiter_if #(.ADDR_W(24)) mif ();
  tape_mem_arbiter_if #(.ADDR_W(4))  mif4 ();

  tape_mem_arbiter u_dut (
    .clk50m(clk50m), .reset(reset), .cmd_play(cmd_play), .cmd_record(cmd_record),
    .cmd_stop(cmd_stop), .cmd_rewind(cmd_rewind), .host_wr(host_wr), .host_data(host_data),
    .host_clear(host_clear), .host_busy(host_busy), .ld_req(ld_req), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_dend(ld_dend), .sv_valid(sv_valid), .sv_end(sv_end),
    .sv_data(sv_data), .sv_ack(sv_ack), .play(play), .recording(recording),
    .overflow(overflow), .tape_len(tape_len), .mem(mif)
  );

  tape_mem_arbiter #(.ADDR_W(4), .BASE_ADDR(4'h0)) u_small (
    .clk50m(clk50m), .reset(reset), .cmd_play(cmd_play), .cmd_record(cmd_record),
    .cmd_stop(cmd_stop), .cmd_rewind(cmd_rewind), .host_wr(host_wr), .host_data(host_data),
    .host_clear(host_clear), .host_busy(host_busy4), .ld_req(ld_req), .ld_data(ld_data4),
    .ld_ready(ld_ready4), .ld_dend(ld_dend4), .sv_valid(sv_valid), .sv_end(sv_end),
    .sv_data(sv_data), .sv_ack(sv_ack4), .play(play4), .recording(recording4),
    .overflow(overflow4), .tape_len(tape_len4), .mem(mif4)
  );

  always #5 clk50m = ~clk50m;

  // Main memory stub: ack on the second falling edge of a held strobe; logs every write.
  logic        resp_en = 1'b1;
  logic        ack_r = 1'b0;
  logic [7:0]  rdata_r = 8'h00;
  int          lat_cnt = 0;
  int          rd_cnt = 0;
  logic [7:0]  mem_arr [256];
  logic [23:0] wa_q [$];
  logic [7:0]  wd_q [$];
  assign mif.mem_ack   = ack_r;
  assign mif.mem_rdata = rdata_r;

  always @(negedge clk50m) begin
    if (ack_r) begin
      ack_r <= 1'b0;
    end else if (resp_en && (mif.mem_rd || mif.mem_wr)) begin
      if (lat_cnt == 1) begin
        ack_r   <= 1'b1;
        lat_cnt <= 0;
        if (mif.mem_wr) begin
          mem_arr[mif.mem_addr[7:0]] <= mif.mem_wdata;
          wa_q.push_back(mif.mem_addr);
          wd_q.push_back(mif.mem_wdata);
        end else begin
          rdata_r <= mem_arr[mif.mem_addr[7:0]];
          rd_cnt  <= rd_cnt + 1;
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      lat_cnt <= 0;
    end
  end

  logic       ack4_r = 1'b0;
  int         wcnt4 = 0;
  logic [3:0] last_a4 = 4'h0;
  assign mif4.mem_ack   = ack4_r;
  assign mif4.mem_rdata = 8'h00;

  always @(negedge clk50m) begin
    if (ack4_r) begin
      ack4_r <= 1'b0;
    end else if (mif4.mem_rd || mif4.mem_wr) begin
      ack4_r <= 1'b1;
      if (mif4.mem_wr) begin
        wcnt4   <= wcnt4 + 1;
        last_a4 <= mif4.mem_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] host_bytes [3] = '{8'h13, 8'h00, 8'hFF};
  logic [7:0] exp_ld     [4] = '{8'h13, 8'h00, 8'hFF, 8'h00};
  logic       exp_dend   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int rc0, wsz, w4_base, tog;
    logic prev;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_out", {host_busy, ld_data, ld_ready, ld_dend, sv_ack, play, recording, overflow}, 0);
    check("rst_len", tape_len, 0);
    check("rst_strobes", {mif.mem_rd, mif.mem_wr}, 0);
    check("rst_small", {host_busy4, ld_data4, ld_ready4, ld_dend4, sv_ack4, play4, recording4,
                        overflow4, tape_len4}, 0);

    // Host appends three bytes
    for (int i = 0; i < 3; i++) begin
      host_data = host_bytes[i];
      host_wr = 1'b1;
      tick();
      host_wr = 1'b0;
      check("host_busy_set", host_busy, 1);
      for (int t = 0; t < 20 && host_busy; t++) tick();
      check("host_busy_clr", host_busy, 0);
      check("host_wr_cnt", wa_q.size(), i + 1);
      check("host_wr_addr", wa_q[wa_q.size()-1], BASE + 24'(i));
      check("host_wr_data", wd_q[wd_q.size()-1], host_bytes[i]);
    end
    check("host_len", tape_len, 3);

    // Playback: three bytes then end-of-data without a memory read
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    check("play_on", play, 1);
    for (int k = 0; k < 4; k++) begin
      rc0 = rd_cnt;
      ld_req = 1'b1;
      for (int t = 0; t < 20 && !ld_ready; t++) tick();
      check("ld_ready", ld_ready, 1);
      check("ld_data", ld_data, exp_ld[k]);
      check("ld_dend", ld_dend, exp_dend[k]);
      check("ld_rdcnt", rd_cnt - rc0, (k < 3) ? 1 : 0);
      ld_req = 1'b0;
      tick(); tick();
      check("ld_release", ld_ready, 0);
    end

    // Record: one saver byte then end of block
    cmd_record = 1'b1; tick(); cmd_record = 1'b0;
    check("rec_on", {recording, play}, 2'b10);
    check("rec_len_clr", tape_len, 0);
    sv_data = 8'hAA;
    sv_valid = 1'b1;
    for (int t = 0; t < 20 && !sv_ack; t++) tick();
    sv_valid = 1'b0;
    check("sv_ack_byte", sv_ack, 1);
    check("sv_wr_addr", wa_q[wa_q.size()-1], BASE);
    check("sv_wr_data", wd_q[wd_q.size()-1], 8'hAA);
    tick(); tick();
    sv_end = 1'b1;
    for (int t = 0; t < 20 && sv_ack; t++) tick();
    sv_end = 1'b0;
    check("sv_ack_end", sv_ack, 0);
    check("rec_off", recording, 0);
    check("rec_len", tape_len, 1);

    // Host write collides with loader request during playback
    cmd_rewind = 1'b1; tick(); cmd_rewind = 1'b0;
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    wsz = wa_q.size();
    rc0 = rd_cnt;
    host_data = 8'h55;
    host_wr = 1'b1;
    ld_req = 1'b1;
    tick();
    host_wr = 1'b0;
    for (int t = 0; t < 20 && !ld_ready; t++) tick();
    check("col_ld_data", ld_data, 8'hAA);
    check("col_rd_first", rd_cnt - rc0, 1);
    check("col_no_wr", wa_q.size(), wsz);
    ld_req = 1'b0;
    repeat (5) tick();
    check("col_held", {host_busy, 8'(wa_q.size() - wsz)}, 9'h100);
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
    for (int t = 0; t < 20 && host_busy; t++) tick();
    check("col_wr_addr", wa_q[wa_q.size()-1], BASE + 24'd1);
    check("col_wr_data", wd_q[wd_q.size()-1], 8'h55);
    check("col_len", tape_len, 2);

    // Reset with a read outstanding
    cmd_rewind = 1'b1; tick(); cmd_rewind = 1'b0;
    cmd_play = 1'b1; tick(); cmd_play = 1'b0;
    resp_en = 1'b0;
    ld_req = 1'b1;
    tick();
    check("mid_rd_high", mif.mem_rd, 1);
    reset = 1'b1;
    tick();
    check("mid_rd_drop", mif.mem_rd, 0);
    check("mid_ld_ready", ld_ready, 0);
    check("mid_len", tape_len, 0);
    reset = 1'b0;
    ld_req = 1'b0;
    resp_en = 1'b1;
    tick(); tick();
    check("mid_after", {ld_ready, play, mif.mem_rd}, 0);

    // Address limit on the 4-bit instance
    w4_base = wcnt4;
    tog = 0;
    cmd_record = 1'b1; tick(); cmd_record = 1'b0;
    for (int i = 0; i < 16; i++) begin
      prev = sv_ack4;
      sv_data = 8'h40 + 8'(i);
      sv_valid = 1'b1;
      for (int t = 0; t < 20 && sv_ack4 == prev; t++) tick();
      if (sv_ack4 != prev) tog++;
      sv_valid = 1'b0;
      repeat (3) tick();
    end
    check("lim_toggles", tog, 16);
    check("lim_writes", wcnt4 - w4_base, 15);
    check("lim_last_addr", last_a4, 4'hE);
    check("lim_overflow", overflow4, 1);
    check("lim_len", tape_len4, 15);
    check("big_no_overflow", {overflow, tape_len}, 25'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tape_mem_arbiter.md
Name: tape_mem_arbiter

Overview:
Controls the tape byte buffer in SDRAM, which three requesters share: the host (ctrl module writing a .tap image), the tape saver (bytes captured from EAR) and the tape loader (bytes replayed to EAR). The block holds the play/record mode, the read/write pointers and the tape length. It drives a single byte-wide memory port and generates the loader's end-of-data flag. It sits on the clk50m side, between the loader/saver handshakes and the SDRAM controller.

Parameters:
ADDR_W, 24, width of the byte address and of the length counters
BASE_ADDR, 24'h100000, SDRAM byte address of tape byte 0

Ports:
clk50m  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_play  in  1  one-cycle pulse: start playback from rd_ptr
cmd_record  in  1  one-cycle pulse: clear the tape and start recording
cmd_stop  in  1  one-cycle pulse: return to idle
cmd_rewind  in  1  one-cycle pulse: rd_ptr <= 0, mode <= idle
host_wr  in  1  one-cycle pulse: append host_data to the tape
host_data  in  8  host byte
host_clear  in  1  one-cycle pulse: tape_len <= 0, wr_ptr <= 0, rd_ptr <= 0
host_busy  out  1  host byte pending (host must not pulse host_wr while high)
ld_req  in  1  loader data request (level)
ld_data  out  8  byte returned to the loader
ld_ready  out  1  ld_data/ld_dend valid
ld_dend  out  1  returned byte is past the end of the tape
sv_valid  in  1  saver byte available (xor level)
sv_end  in  1  saver end of block (xor level)
sv_data  in  8  saver byte
sv_ack  out  1  toggles once per consumed saver event
play  out  1  drives the loader play input
recording  out  1  record mode active
overflow  out  1  sticky: a write was dropped at the address limit
tape_len  out  ADDR_W  bytes stored
mem_addr  out  ADDR_W  BASE_ADDR + pointer
mem_wdata  out  8  write data
mem_rd  out  1  read strobe, held until mem_ack
mem_wr  out  1  write strobe, held until mem_ack
mem_rdata  in  8  read data, valid with mem_ack
mem_ack  in  1  one-cycle transaction completion

Behaviour:
- Reset: all outputs 0; pointers, tape_len and overflow cleared; both FSMs idle.
- Reset mid-transaction: mem_rd and mem_wr drop in the next cycle; the in-flight result is discarded.
- Mode FSM states: IDLE, PLAY, RECORD.
  - Command priority when several arrive together: rewind > stop > record > play.
  - play = (mode==PLAY); recording = (mode==RECORD).
  - cmd_record: clears wr_ptr, tape_len and overflow.
  - cmd_play while in RECORD is ignored.
- Memory FSM states: M_IDLE, M_RD, M_WR, M_LDWAIT.
  - One transaction in flight at a time.
  - Grant is evaluated only in M_IDLE, with fixed priority: host > saver > loader.
  - mem_addr and mem_wdata are stable while a strobe is high.
- Host request:
  - host_wr latches host_data and sets host_busy.
  - Served by a write at wr_ptr; on mem_ack: wr_ptr++, tape_len <= wr_ptr+1, host_busy <= 0.
  - Honoured only when mode != PLAY; otherwise the byte is held until the mode allows it.
- Saver request:
  - Eligible when mode==RECORD, sv_valid high and sv_pend==0.
  - Served by a write at wr_ptr; on mem_ack: wr_ptr++, tape_len update, sv_ack toggles, sv_pend <= 1.
  - sv_pend clears when both sv_valid and sv_end read low.
  - sv_end high with sv_pend==0: toggle sv_ack, set sv_pend, mode <= IDLE. No memory access.
- Loader request:
  - Eligible when mode==PLAY, ld_req high and ld_ready==0.
  - If rd_ptr >= tape_len: no memory access; the next cycle gives ld_data=0, ld_dend=1, ld_ready=1.
  - Otherwise read at rd_ptr; on mem_ack the next cycle gives ld_data=mem_rdata, ld_dend=0, ld_ready=1, rd_ptr++.
  - Then M_LDWAIT: ld_ready holds until ld_req reads low, then clears, then M_IDLE.
- Address limit: a write when wr_ptr == 2^ADDR_W-1 is not issued; set overflow and still complete the handshake (sv_ack toggles / host_busy clears).
- host_clear while a transaction is in flight: applied after mem_ack; the completed write does not update tape_len.

Decomposition:
- tape_pkg: mode and memory-FSM state encodings, and the grant-source encoding (GNT_HOST/GNT_SAVER/GNT_LOADER).
- One natural sub-module: tape_req_prio, a combinational fixed-priority grant over the three eligibility signals.

Test Plan:
1. Host writes 0x13,0x00,0xFF via host_wr -> three mem_wr at BASE_ADDR+0..2, tape_len=3, host_busy low after each mem_ack.
2. cmd_play, loader pulses ld_req 4 times -> ld_data=0x13,0x00,0xFF with ld_dend=0, fourth gives ld_dend=1, ld_data=0 and no mem_rd.
3. cmd_record, saver toggles sv_valid with 0xAA then sv_end -> one write of 0xAA, sv_ack toggles twice, tape_len=1, recording falls.
4. host_wr and ld_req rise in the same cycle during PLAY -> no host write until mode leaves PLAY; loader read is served first.
5. reset asserted while mem_rd is high -> mem_rd=0 next cycle, ld_ready stays 0, tape_len=0.
6. ADDR_W=4, 16 saver bytes -> 15 written, overflow=1, sv_ack toggles 16 times.
